// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier: one partial product per enabled clock, WIDTH-bit
// operands, run-time signed/unsigned mode and a start/busy/done handshake.
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sm);
        logic [WIDTH-1:0] m;
        if (sm && v[WIDTH-1]) begin
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_of(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]     mag_b_r, mag_b_nxt_s;
    logic [2*WIDTH-1:0]   mcand_r, mcand_nxt_s;
    logic [2*WIDTH-1:0]   acc_r, acc_nxt_s;
    logic                 neg_r, neg_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;
    logic [2*WIDTH-1:0]   product_r, product_nxt_s;

    // Next-state and datapath update; everything holds while ena is low.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        mag_b_nxt_s   = mag_b_r;
        mcand_nxt_s   = mcand_r;
        acc_nxt_s     = acc_r;
        neg_nxt_s     = neg_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = done_r;
        product_nxt_s = product_r;
        if (ena) begin
            done_nxt_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                        busy_nxt_s  = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        mag_b_nxt_s = mag_of(b, signed_mode);
                        mcand_nxt_s = {{WIDTH{1'b0}}, mag_of(a, signed_mode)};
                        neg_nxt_s   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_nxt_s   = {(2*WIDTH){1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The multiplicand register is pre-shifted, so it always equals mag_a << counter.
                    if (mag_b_r[0]) begin
                        acc_nxt_s = acc_r + mcand_r;
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                    mcand_nxt_s = mcand_r << 1;
                    mag_b_nxt_s = mag_b_r >> 1;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FIX: begin
                    product_nxt_s = neg_r ? neg_of(acc_r) : acc_r;
                    done_nxt_s    = 1'b1;
                    busy_nxt_s    = 1'b0;
                    state_nxt_s   = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            mag_b_r   <= {WIDTH{1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mag_b_r   <= mag_b_nxt_s;
            mcand_r   <= mcand_nxt_s;
            acc_r     <= acc_nxt_s;
            neg_r     <= neg_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            product_r <= product_nxt_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: WIDTH=8 and WIDTH=4 instances checked
// against an integer-arithmetic reference model.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = 4'd0, b4 = 4'd0;
    logic        busy4, done4;
    logic [7:0]  product4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
    );

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
    );

    // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic longint ref_mult(int w, longint av, longint bv, bit sm);
        longint va = av;
        longint vb = bv;
        longint half = longint'(64'd1) << (w - 1);
        longint full = longint'(64'd1) << w;
        if (sm && va >= half) va = va - full;
        if (sm && vb >= half) vb = vb - full;
        return (va * vb) & ((longint'(64'd1) << (2 * w)) - 1);
    endfunction

    // Drives one start pulse (called at a negedge) and waits for done, bounded.
    task automatic run_op(input bit use4, input logic [7:0] av, input logic [7:0] bv, input bit smv,
                          output int lat, output int busy_n, output bit early);
        logic [15:0] prev;
        prev = use4 ? {8'd0, product4} : product8;
        if (use4) begin a4 = av[3:0]; b4 = bv[3:0]; sm4 = smv; start4 = 1'b1; end
        else begin a8 = av; b8 = bv; sm8 = smv; start8 = 1'b1; end
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        lat = 1; busy_n = 0; early = 1'b0;
        while (!(use4 ? done4 : done8) && lat < 100) begin
            busy_n += int'(use4 ? busy4 : busy8);
            if ((use4 ? {8'd0, product4} : product8) !== prev) early = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!(use4 ? done4 : done8)) lat = -1;
    endtask

    task automatic test_reset();
        n_cmp++; if ({busy8, done8, product8} !== 18'd0) begin
            n_err++; $display("FAIL reset8 got busy=%b done=%b product=%h want 0/0/0000", busy8, done8, product8); end
        n_cmp++; if ({busy4, done4, product4} !== 10'd0) begin
            n_err++; $display("FAIL reset4 got busy=%b done=%b product=%h want 0/0/00", busy4, done4, product4); end
    endtask

    task automatic test_unsigned_max();
        int lat, bn; bit early;
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0, lat, bn, early);
        n_cmp++; if (product8 !== 16'hFE01) begin n_err++; $display("FAIL umax_product got %h want fe01", product8); end
        n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL umax_latency got %0d want 10", lat); end
        n_cmp++; if (bn !== 9) begin n_err++; $display("FAIL umax_busy_cycles got %0d want 9", bn); end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL umax_product_early got %b want 0", early); end
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL umax_busy_at_done got %b want 0", busy8); end
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL umax_done_pulse got %b want 0", done8); end
    endtask

    task automatic test_signed_vectors();
        logic [7:0]  va [3] = '{8'hFD, 8'h80, 8'h7F};
        logic [7:0]  vb [3] = '{8'h05, 8'h80, 8'h80};
        logic [15:0] vp [3] = '{16'hFFF1, 16'h4000, 16'hC080};
        int lat, bn; bit early;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, va[i], vb[i], 1'b1, lat, bn, early);
            n_cmp++; if (product8 !== vp[i]) begin
                n_err++; $display("FAIL signed8_%0d got %h want %h", i, product8, vp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_width4();
        int lat, bn; bit early;
        run_op(1'b1, 8'h0F, 8'h0F, 1'b0, lat, bn, early);
        n_cmp++; if (product4 !== 8'hE1) begin n_err++; $display("FAIL w4_unsigned got %h want e1", product4); end
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL w4_latency got %0d want 6", lat); end
        @(negedge clk);
        run_op(1'b1, 8'h08, 8'h07, 1'b1, lat, bn, early);
        n_cmp++; if (product4 !== 8'hC8) begin n_err++; $display("FAIL w4_signed got %h want c8", product4); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bn; bit early;
        logic [7:0] ra, rb; bit rs; longint expv;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) ra = 8'd0;
            if (i % 8 == 1) begin ra = 8'h80; rs = 1'b1; end
            expv = ref_mult(8, longint'(ra), longint'(rb), rs);
            run_op(1'b0, ra, rb, rs, lat, bn, early);
            n_cmp++; if (product8 !== 16'(expv) || lat !== 10) begin
                n_err++; $display("FAIL rand8_%0d a=%h b=%h s=%b got %h lat=%0d want %h lat=10",
                                  i, ra, rb, rs, product8, lat, 16'(expv)); end
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            expv = ref_mult(4, longint'(ra[3:0]), longint'(rb[3:0]), rs);
            run_op(1'b1, ra, rb, rs, lat, bn, early);
            n_cmp++; if (product4 !== 8'(expv) || lat !== 6) begin
                n_err++; $display("FAIL rand4_%0d a=%h b=%h s=%b got %h lat=%0d want %h lat=6",
                                  i, ra[3:0], rb[3:0], rs, product4, lat, 8'(expv)); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a1, b1, a2, b2; longint e1, e2; int lat, extra;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        e1 = ref_mult(8, longint'(a1), longint'(b1), 1'b1);
        e2 = ref_mult(8, longint'(a2), longint'(b2), 1'b1);
        sm8 = 1'b1; a8 = a1; b8 = b1; start8 = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done8 && lat < 100) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(negedge clk); lat++;
        end
        n_cmp++; if (product8 !== 16'(e1) || lat !== 10) begin
            n_err++; $display("FAIL held_first got %h lat=%0d want %h lat=10", product8, lat, 16'(e1)); end
        a8 = a2; b8 = b2; sm8 = 1'b1;
        @(negedge clk);
        lat = 1; extra = 0;
        while (!done8 && lat < 100) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(negedge clk); lat++;
        end
        start8 = 1'b0;
        n_cmp++; if (product8 !== 16'(e2) || lat !== 10) begin
            n_err++; $display("FAIL held_second got %h lat=%0d want %h lat=10", product8, lat, 16'(e2)); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL held_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_ena_stall();
        int lat;
        sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; lat = 1;
        while (!done8 && lat < 100) begin
            if (lat == 4) ena = 1'b0;
            if (lat == 7) ena = 1'b1;
            @(negedge clk); lat++;
        end
        n_cmp++; if (product8 !== 16'h0258 || lat !== 13) begin
            n_err++; $display("FAIL stall got %h lat=%0d want 0258 lat=13", product8, lat); end
        ena = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (done8 !== 1'b1 || product8 !== 16'h0258) begin
            n_err++; $display("FAIL stall_done_hold got done=%b product=%h want 1/0258", done8, product8); end
        ena = 1'b1;
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL stall_done_clear got %b want 0", done8); end
    endtask

    task automatic test_async_reset();
        int lat, bn, spurious; bit early;
        sm8 = 1'b0; a8 = 8'd77; b8 = 8'd5; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy8, done8, product8} !== 18'd0) begin
            n_err++; $display("FAIL async_reset got busy=%b done=%b product=%h want 0/0/0000", busy8, done8, product8); end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8 || busy8) spurious++;
        end
        n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL reset_abort got %0d want 0", spurious); end
        run_op(1'b0, 8'd12, 8'd11, 1'b0, lat, bn, early);
        n_cmp++; if (product8 !== 16'h0084 || lat !== 10) begin
            n_err++; $display("FAIL post_reset got %h lat=%0d want 0084 lat=10", product8, lat); end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_unsigned_max();
        test_signed_vectors();
        test_width4();
        test_random();
        test_back_to_back();
        test_ena_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
